// File: rtl/int_ctrl.sv
// Four-source interrupt controller: synchronizes raw requests, latches them as pending,
// and dispatches one fixed-priority request at a time through fetch's ack and the rti return.
module int_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] interrupt_taken,
  input  logic               rti,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic [NUM_IRQ-1:0] int_req,
  output logic               irq_busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ISSUE      = 2'b01,
    WAIT_TAKEN = 2'b10,
    IN_SERVICE = 2'b11
  } state_e;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   s1_q, s2_q, s2d_q;
  logic [NUM_IRQ-1:0]   pend_q, pend_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   mode_q, mode_d;
  logic [NUM_IRQ-1:0]   active_q, active_d;
  logic [NUM_IRQ-1:0]   int_req_q, int_req_d;

  logic [NUM_IRQ-1:0]   edge_det;
  logic [NUM_IRQ-1:0]   set_vec;
  logic [NUM_IRQ-1:0]   w1c_vec;
  logic [NUM_IRQ-1:0]   ack_vec;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   winner;

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:NUM_IRQ];

  // Edge mode sets on the rising edge only; level mode sets every cycle the line is high.
  assign edge_det = s2_q & ~s2d_q;
  assign set_vec  = (mode_q & edge_det) | (~mode_q & s2_q);
  assign eligible = pend_q & mask_q;

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end

  always_comb begin
    mask_d  = mask_q;
    mode_d  = mode_q;
    w1c_vec = '0;
    if (reg_we) begin
      case (reg_addr)
        ADDR_MASK: mask_d  = reg_wdata[NUM_IRQ-1:0];
        ADDR_PEND: w1c_vec = reg_wdata[NUM_IRQ-1:0];
        ADDR_MODE: mode_d  = reg_wdata[NUM_IRQ-1:0];
        default:   ;
      endcase
    end
  end

  // int_req_d is only loaded on the IDLE->ISSUE transition, so the registered pulse
  // lines up exactly with the ISSUE cycle.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    int_req_d = '0;
    ack_vec   = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          active_d  = winner;
          int_req_d = winner;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_TAKEN;
      end
      WAIT_TAKEN: begin
        if (interrupt_taken == active_q) begin
          ack_vec = active_q;
          state_d = IN_SERVICE;
        end
      end
      IN_SERVICE: begin
        if (rti) begin
          active_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = '0;
      end
    endcase
  end

  // A new set in the same cycle as a clear must survive.
  assign pend_d = (pend_q & ~(w1c_vec | ack_vec)) | set_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s2d_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      mode_q    <= '1;
      active_q  <= '0;
      int_req_q <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= irq_src;
      s2_q      <= s1_q;
      s2d_q     <= s2_q;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      active_q  <= active_d;
      int_req_q <= int_req_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_MASK:   reg_rdata = {{(32-NUM_IRQ){1'b0}}, mask_q};
      ADDR_PEND:   reg_rdata = {{(32-NUM_IRQ){1'b0}}, pend_q};
      ADDR_MODE:   reg_rdata = {{(32-NUM_IRQ){1'b0}}, mode_q};
      ADDR_STATUS: reg_rdata = {{(28-NUM_IRQ){1'b0}}, state_q, 2'b00, active_q};
      default:     reg_rdata = '0;
    endcase
  end

  assign int_req  = int_req_q;
  assign irq_busy = (state_q != IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, single edge dispatch, priority, masking/W1C,
// level re-dispatch and reset in the middle of a dispatch.
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic [3:0]  interrupt_taken;
  logic        rti;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic [3:0]  int_req;
  logic        irq_busy;

  int total;
  int bad;

  int_ctrl #(.NUM_IRQ(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .irq_src         (irq_src),
    .interrupt_taken (interrupt_taken),
    .rti             (rti),
    .reg_we          (reg_we),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .int_req         (int_req),
    .irq_busy        (irq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic wait_req(input int budget, output logic found);
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (int_req !== 4'b0000) found = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    irq_src = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    irq_src = 4'hF;
    repeat (2) @(negedge clk);
    total++;
    if (int_req !== 4'b0000) begin bad++; $display("FAIL reset_int_req got=%b exp=0000", int_req); end
    total++;
    if (irq_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", irq_busy); end
    reg_read(2'd0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=00000000", d); end
    reg_read(2'd2, d);
    total++;
    if (d !== 32'hF) begin bad++; $display("FAIL reset_mode got=%h exp=0000000f", d); end
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h exp=00000000", d); end
    irq_src = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL post_reset_pend got=%h exp=00000000", d); end
  endtask

  task automatic test_single_edge();
    logic [31:0] d;
    logic [3:0]  exp;
    reg_write(2'd0, 32'h4);
    irq_src = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) irq_src = '0;
      exp = (k == 4) ? 4'b0100 : 4'b0000;
      total++;
      if (int_req !== exp) begin bad++; $display("FAIL edge_req_cycle%0d got=%b exp=%b", k, int_req, exp); end
    end
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h84) begin bad++; $display("FAIL edge_status_wait got=%h exp=00000084", d); end
    total++;
    if (irq_busy !== 1'b1) begin bad++; $display("FAIL edge_busy_wait got=%b exp=1", irq_busy); end
    interrupt_taken = 4'b0100;
    @(negedge clk);
    interrupt_taken = '0;
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL edge_pend_after_ack got=%h exp=00000000", d); end
    reg_read(2'd3, d);
    total++;
    if (d !== 32'hC4) begin bad++; $display("FAIL edge_status_svc got=%h exp=000000c4", d); end
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL edge_status_idle got=%h exp=00000000", d); end
    total++;
    if (irq_busy !== 1'b0) begin bad++; $display("FAIL edge_busy_idle got=%b exp=0", irq_busy); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic        found;
    reg_write(2'd0, 32'hF);
    irq_src = 4'b1010;
    @(negedge clk);
    irq_src = '0;
    wait_req(10, found);
    total++;
    if (!found || int_req !== 4'b0010) begin bad++; $display("FAIL prio_first got=%b exp=0010", int_req); end
    @(negedge clk);
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h82) begin bad++; $display("FAIL prio_rti_ignored got=%h exp=00000082", d); end
    interrupt_taken = 4'b0010;
    @(negedge clk);
    interrupt_taken = '0;
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL prio_pend_left got=%h exp=00000008", d); end
    reg_read(2'd3, d);
    total++;
    if (d !== 32'hC2) begin bad++; $display("FAIL prio_status_svc got=%h exp=000000c2", d); end
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
    total++;
    if (int_req !== 4'b0000) begin bad++; $display("FAIL prio_gap got=%b exp=0000", int_req); end
    @(negedge clk);
    total++;
    if (int_req !== 4'b1000) begin bad++; $display("FAIL prio_second got=%b exp=1000", int_req); end
    @(negedge clk);
    interrupt_taken = 4'b1000;
    @(negedge clk);
    interrupt_taken = '0;
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL prio_end_status got=%h exp=00000000", d); end
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL prio_end_pend got=%h exp=00000000", d); end
  endtask

  task automatic test_masked_w1c();
    logic [31:0] d;
    logic        seen;
    reg_write(2'd0, 32'h0);
    irq_src = 4'b0001;
    @(negedge clk);
    irq_src = '0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (int_req !== 4'b0000) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL masked_no_req got=req exp=none"); end
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL masked_pend got=%h exp=00000001", d); end
    reg_write(2'd1, 32'h1);
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL w1c_pend got=%h exp=00000000", d); end
    reg_write(2'd0, 32'hFFFF_FFF1);
    reg_read(2'd0, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL mask_unused_bits got=%h exp=00000001", d); end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (int_req !== 4'b0000) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL w1c_no_req got=req exp=none"); end
    reg_write(2'd3, 32'hFFFF_FFFF);
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL status_ro got=%h exp=00000000", d); end
    reg_write(2'd0, 32'h0);
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic        found;
    reg_write(2'd2, 32'h0);
    reg_write(2'd0, 32'h2);
    irq_src = 4'b0010;
    wait_req(10, found);
    total++;
    if (!found || int_req !== 4'b0010) begin bad++; $display("FAIL level_first got=%b exp=0010", int_req); end
    @(negedge clk);
    interrupt_taken = 4'b0010;
    @(negedge clk);
    interrupt_taken = '0;
    reg_read(2'd1, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL level_repend got=%h exp=00000002", d); end
    reg_read(2'd3, d);
    total++;
    if (d !== 32'hC2) begin bad++; $display("FAIL level_status_svc got=%h exp=000000c2", d); end
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
    total++;
    if (int_req !== 4'b0000) begin bad++; $display("FAIL level_gap got=%b exp=0000", int_req); end
    @(negedge clk);
    total++;
    if (int_req !== 4'b0010) begin bad++; $display("FAIL level_redispatch got=%b exp=0010", int_req); end
    do_reset();
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic        found;
    logic        seen;
    reg_write(2'd0, 32'h4);
    irq_src = 4'b0100;
    @(negedge clk);
    irq_src = '0;
    wait_req(10, found);
    total++;
    if (!found || int_req !== 4'b0100) begin bad++; $display("FAIL midrst_req got=%b exp=0100", int_req); end
    @(negedge clk);
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h84) begin bad++; $display("FAIL midrst_wait got=%h exp=00000084", d); end
    reset = 1'b1;
    @(negedge clk);
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_status got=%h exp=00000000", d); end
    total++;
    if (irq_busy !== 1'b0 || int_req !== 4'b0000) begin
      bad++; $display("FAIL midrst_outputs got=busy%b req%b exp=busy0 req0000", irq_busy, int_req);
    end
    reset = 1'b0;
    interrupt_taken = 4'b0100;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (int_req !== 4'b0000) seen = 1'b1;
    end
    interrupt_taken = '0;
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL midrst_stale_ack got=%h exp=00000000", d); end
    total++;
    if (seen || irq_busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=busy%b exp=busy0 noreq", irq_busy); end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    irq_src         = '0;
    interrupt_taken = '0;
    rti             = 1'b0;
    reg_we          = 1'b0;
    reg_addr        = '0;
    reg_wdata       = '0;
    test_reset();
    test_single_edge();
    test_priority();
    test_masked_w1c();
    test_level();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
